// File: rtl/mem_resp.sv
// mem_resp: dual-requester memory responder with a 2^MEM_AW x 16-bit array.
// Instruction and data sides request eight-word block reads; the data side can
// also do single-word writes. Data side has fixed priority. A granted read
// streams eight words through a LATENCY-cycle response pipeline.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_req, i_addr              instruction block-read request (level) and byte address
//   d_req, d_wr, d_addr,       data request (level), 1=write/0=block read,
//   d_wdata                    byte address and write data
//   i_grant, d_grant           combinational accept strobes (IDLE only)
//   resp_valid, resp_owner     response word valid; burst owner (0=I, 1=D)
//   resp_data, resp_addr       returned word and its byte address
//   resp_last                  eighth and final word of the burst
//   wr_ack                     one-cycle pulse after an accepted write
//   busy                       read burst in progress
module mem_resp #(
    parameter int unsigned LATENCY = 4,   // 2..8
    parameter int unsigned MEM_AW  = 15   // 1..15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        i_grant,
    output logic        d_grant,
    output logic        resp_valid,
    output logic        resp_owner,
    output logic [15:0] resp_data,
    output logic [15:0] resp_addr,
    output logic        resp_last,
    output logic        wr_ack,
    output logic        busy
);

    // Word issue occupies one cycle, the remaining LATENCY-1 cycles are
    // register stages; the last stage drives the response outputs.
    localparam int unsigned NSTG  = LATENCY - 1;
    localparam int unsigned DEPTH = 1 << MEM_AW;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [15:0]       mem [DEPTH];

    logic [11:0]       base_q;        // block base, byte address bits [15:4]
    logic [2:0]        issue_cnt_q;   // word offset being issued
    logic              issue_done_q;  // all eight words issued
    logic              issue_act;
    logic              rd_accept;
    logic              wr_accept;
    logic [15:0]       req_addr;
    logic [15:0]       issue_addr;
    logic [MEM_AW-1:0] rd_idx;
    logic [MEM_AW-1:0] wr_idx;
    logic              unused_bits;

    logic [NSTG-1:0]   pv;            // per-stage valid
    logic [NSTG-1:0]   pl;            // per-stage last-word flag
    logic [15:0]       pa [NSTG];     // per-stage byte address
    logic [15:0]       pd [NSTG];     // per-stage data

    // Arbitration: grants only in IDLE, data side wins.
    always_comb begin
        d_grant = 1'b0;
        i_grant = 1'b0;
        if (state_q == S_IDLE) begin
            d_grant = d_req;
            i_grant = i_req & ~d_req;
        end
    end

    assign rd_accept  = (d_grant & ~d_wr) | i_grant;
    assign wr_accept  = d_grant & d_wr;
    assign req_addr   = d_grant ? d_addr : i_addr;
    assign issue_act  = (state_q == S_BURST) & ~issue_done_q;
    assign issue_addr = {base_q, issue_cnt_q, 1'b0};

    // Bit 0 and bits above MEM_AW are dropped, so addresses wrap.
    assign rd_idx     = issue_addr[MEM_AW:1];
    assign wr_idx     = d_addr[MEM_AW:1];

    assign unused_bits = ^{req_addr, issue_addr, d_addr};

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (rd_accept) state_d = S_BURST;
            S_BURST: if (resp_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register, burst context and issue counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            busy         <= 1'b0;
            wr_ack       <= 1'b0;
            resp_owner   <= 1'b0;
            base_q       <= '0;
            issue_cnt_q  <= '0;
            issue_done_q <= 1'b1;
        end else begin
            state_q <= state_d;
            busy    <= (state_d == S_BURST);
            wr_ack  <= wr_accept;
            if (rd_accept) begin
                base_q       <= req_addr[15:4];
                resp_owner   <= d_grant;
                issue_cnt_q  <= '0;
                issue_done_q <= 1'b0;
            end else if (issue_act) begin
                issue_cnt_q <= issue_cnt_q + 3'd1;
                if (issue_cnt_q == 3'd7) begin
                    issue_done_q <= 1'b1;
                end
            end
        end
    end

    // Array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_idx] <= d_wdata;
        end
    end

    // Response pipeline. Data/address only advance with a valid word so the
    // outputs hold their last values between bursts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            pl <= '0;
            for (int unsigned i = 0; i < NSTG; i++) begin
                pa[i] <= '0;
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= issue_act;
            pl[0] <= issue_act & (issue_cnt_q == 3'd7);
            if (issue_act) begin
                pa[0] <= issue_addr;
                pd[0] <= mem[rd_idx];
            end
            for (int unsigned i = 1; i < NSTG; i++) begin
                pv[i] <= pv[i-1];
                pl[i] <= pl[i-1];
                if (pv[i-1]) begin
                    pa[i] <= pa[i-1];
                    pd[i] <= pd[i-1];
                end
            end
        end
    end

    assign resp_valid = pv[NSTG-1];
    assign resp_last  = pl[NSTG-1];
    assign resp_addr  = pa[NSTG-1];
    assign resp_data  = pd[NSTG-1];

endmodule
